// File: rtl/mem_store_load_ctrl_pkg.sv
// Shared widths, store/load type codes and controller state encoding
// for the byte-serial store/load memory controller.
package mem_store_load_ctrl_pkg;

    localparam int ROB_SIZE_WIDTH       = 5;
    localparam int STORE_TYPE_NUM_WIDTH = 2;

    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] STORE_BYTE = 2'b00;
    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] STORE_HALF = 2'b01;
    localparam logic [STORE_TYPE_NUM_WIDTH-1:0] STORE_WORD = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STORE     = 2'd1,
        S_LOAD      = 2'd2,
        S_LOAD_TAIL = 2'd3
    } ctrl_state_t;

    // Store and load types share the size field in their low two bits.
    function automatic logic [2:0] byte_count(input logic [STORE_TYPE_NUM_WIDTH-1:0] size_code);
        case (size_code)
            STORE_BYTE: byte_count = 3'd1;
            STORE_HALF: byte_count = 3'd2;
            default:    byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_load_ctrl_load_ext.sv
// Sign/zero extension of the assembled little-endian load bytes
// according to the load type.
module mem_load_ext
    import mem_store_load_ctrl_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_value
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        o_value = i_raw;
        case (i_load_type)
            LOAD_LB:  o_value = {{24{i_raw[7]}}, i_raw[7:0]};
            LOAD_LH:  o_value = {{16{i_raw[15]}}, i_raw[15:0]};
            LOAD_LBU: o_value = {24'd0, i_raw[7:0]};
            LOAD_LHU: o_value = {16'd0, i_raw[15:0]};
            default:  o_value = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_store_load_ctrl.sv
// Byte-serial RAM controller: writes committed ROB stores and serves LSB
// loads one byte per cycle, returning extended load results with their tag.
module mem_store_load_ctrl #(
    parameter int ROB_SIZE_WIDTH = mem_store_load_ctrl_pkg::ROB_SIZE_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      need_flush_in,
    input  logic                      rob_store_valid,
    input  logic [1:0]                rob_store_type,
    input  logic [31:0]               rob_store_addr,
    input  logic [31:0]               rob_store_value,
    input  logic                      lsb_load_valid,
    input  logic [2:0]                lsb_load_type,
    input  logic [31:0]               lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH:0]   lsb_load_dep,
    output logic                      lsb_load_ack,
    output logic                      mem_busy,
    output logic                      mem_valid,
    output logic [ROB_SIZE_WIDTH:0]   mem_dependency,
    output logic [31:0]               mem_value,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr
);
    import mem_store_load_ctrl_pkg::*;

    ctrl_state_t               r_state;
    ctrl_state_t               w_state_next;
    logic [31:0]               r_addr;
    logic [31:0]               r_value;
    logic [31:0]               r_raw;
    logic [2:0]                r_ld_type;
    logic [2:0]                r_n;
    logic [2:0]                r_cnt;
    logic [1:0]                r_rd_idx;
    logic [ROB_SIZE_WIDTH:0]   r_dep;
    logic [31:0]               r_mem_a;
    logic [7:0]                r_mem_dout;
    logic                      r_mem_wr;
    logic                      r_ack;
    logic                      r_valid;
    logic [ROB_SIZE_WIDTH:0]   r_mem_dep;
    logic [31:0]               r_mem_value;

    logic                      w_take_store;
    logic                      w_take_load;
    logic                      w_issue;
    logic                      w_capture;
    logic                      w_done;
    logic [31:0]               w_raw_next;
    logic [31:0]               w_ext;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    // r_cnt counts addresses already issued; byte k of a load arrives while address k+1 is out.
    always_comb begin
        w_state_next = r_state;
        w_take_store = 1'b0;
        w_take_load  = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rob_store_valid) begin
                    w_state_next = S_STORE;
                    w_take_store = 1'b1;
                end else if (lsb_load_valid && !need_flush_in) begin
                    w_state_next = S_LOAD;
                    w_take_load  = 1'b1;
                end
            end
            S_STORE: begin
                if (r_cnt == r_n) w_state_next = S_IDLE;
                else              w_issue      = 1'b1;
            end
            S_LOAD: begin
                if (need_flush_in) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_capture = (r_cnt != 3'd1);
                    if (r_cnt == r_n) w_state_next = S_LOAD_TAIL;
                    else              w_issue      = 1'b1;
                end
            end
            S_LOAD_TAIL: begin
                w_state_next = S_IDLE;
                if (!need_flush_in) begin
                    w_capture = 1'b1;
                    w_done    = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_raw_next = r_raw;
        w_raw_next[{r_rd_idx, 3'b000} +: 8] = mem_din;
    end

    mem_load_ext u_load_ext (
        .i_raw       (w_raw_next),
        .i_load_type (r_ld_type),
        .o_value     (w_ext)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_addr      <= '0;
            r_value     <= '0;
            r_raw       <= '0;
            r_ld_type   <= '0;
            r_n         <= 3'd1;
            r_cnt       <= '0;
            r_rd_idx    <= '0;
            r_dep       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_ack       <= 1'b0;
            r_valid     <= 1'b0;
            r_mem_dep   <= '1;
            r_mem_value <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_ack   <= w_take_load;
            r_valid <= w_done;
            if (w_take_store) begin
                r_addr     <= rob_store_addr;
                r_value    <= rob_store_value;
                r_n        <= byte_count(rob_store_type);
                r_cnt      <= 3'd1;
                r_mem_a    <= rob_store_addr;
                r_mem_dout <= rob_store_value[7:0];
                r_mem_wr   <= 1'b1;
            end else if (w_take_load) begin
                r_addr    <= lsb_load_addr;
                r_ld_type <= lsb_load_type;
                r_n       <= byte_count(lsb_load_type[1:0]);
                r_dep     <= lsb_load_dep;
                r_cnt     <= 3'd1;
                r_rd_idx  <= '0;
                r_raw     <= '0;
                r_mem_a   <= lsb_load_addr;
                r_mem_wr  <= 1'b0;
            end else if (w_issue) begin
                r_mem_a <= r_addr + {29'd0, r_cnt};
                r_cnt   <= r_cnt + 3'd1;
                if (r_state == S_STORE) begin
                    r_mem_dout <= r_value[{r_cnt[1:0], 3'b000} +: 8];
                end
            end else begin
                r_mem_wr <= 1'b0;
            end
            if (w_capture) begin
                r_raw    <= w_raw_next;
                r_rd_idx <= r_rd_idx + 2'd1;
            end
            if (w_done) begin
                r_mem_value <= w_ext;
                r_mem_dep   <= r_dep;
            end
        end
    end

    assign mem_busy       = (r_state != S_IDLE) || rob_store_valid;
    assign mem_wr         = r_mem_wr && rdy_in;
    assign mem_a          = r_mem_a;
    assign mem_dout       = r_mem_dout;
    assign lsb_load_ack   = r_ack;
    assign mem_valid      = r_valid;
    assign mem_dependency = r_mem_dep;
    assign mem_value      = r_mem_value;

endmodule

// File: tb/tb_mem_store_load_ctrl.sv
// Directed and randomized bench for mem_store_load_ctrl with a registered
// byte RAM and a reference memory image built from the issued stores.
module tb_mem_store_load_ctrl;

    localparam logic [2:0] T_LB  = 3'b000;
    localparam logic [2:0] T_LH  = 3'b001;
    localparam logic [2:0] T_LW  = 3'b010;
    localparam logic [2:0] T_LBU = 3'b100;
    localparam logic [2:0] T_LHU = 3'b101;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        need_flush_in = 1'b0;
    logic        rob_store_valid = 1'b0;
    logic [1:0]  rob_store_type = '0;
    logic [31:0] rob_store_addr = '0;
    logic [31:0] rob_store_value = '0;
    logic        lsb_load_valid = 1'b0;
    logic [2:0]  lsb_load_type = '0;
    logic [31:0] lsb_load_addr = '0;
    logic [5:0]  lsb_load_dep = '0;
    logic        lsb_load_ack;
    logic        mem_busy;
    logic        mem_valid;
    logic [5:0]  mem_dependency;
    logic [31:0] mem_value;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram       [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    mem_store_load_ctrl #(.ROB_SIZE_WIDTH(5)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .need_flush_in   (need_flush_in),
        .rob_store_valid (rob_store_valid),
        .rob_store_type  (rob_store_type),
        .rob_store_addr  (rob_store_addr),
        .rob_store_value (rob_store_value),
        .lsb_load_valid  (lsb_load_valid),
        .lsb_load_type   (lsb_load_type),
        .lsb_load_addr   (lsb_load_addr),
        .lsb_load_dep    (lsb_load_dep),
        .lsb_load_ack    (lsb_load_ack),
        .mem_busy        (mem_busy),
        .mem_valid       (mem_valid),
        .mem_dependency  (mem_dependency),
        .mem_value       (mem_value),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // Registered RAM: read data for the address seen at an edge appears after that edge.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] code);
        return (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    // Little-endian assembly followed by two's-complement arithmetic for signed types.
    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] raw;
        raw = 0;
        for (int k = 0; k < size_of(t[1:0]); k++)
            raw = raw + ({24'd0, model_byte(a + 32'(k))} << (8 * k));
        case (t)
            T_LB:    return raw[7]  ? raw - 32'd256   : raw;
            T_LH:    return raw[15] ? raw - 32'd65536 : raw;
            default: return raw;
        endcase
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_mem_a"},    mem_a, 32'h0);
        check({pfx, "_mem_dout"}, {24'd0, mem_dout}, 32'h0);
        check({pfx, "_mem_wr"},   {31'd0, mem_wr}, 32'h0);
        check({pfx, "_valid"},    {31'd0, mem_valid}, 32'h0);
        check({pfx, "_dep"},      {26'd0, mem_dependency}, 32'h3F);
        check({pfx, "_value"},    mem_value, 32'h0);
        check({pfx, "_ack"},      {31'd0, lsb_load_ack}, 32'h0);
        check({pfx, "_busy"},     {31'd0, mem_busy}, 32'h0);
    endtask

    task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] v);
        int n;
        n = size_of(t);
        rob_store_valid = 1'b1;
        rob_store_type  = t;
        rob_store_addr  = a;
        rob_store_value = v;
        #1 check("st_busy_present", {31'd0, mem_busy}, 32'd1);
        tick();
        rob_store_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("st_wr",   {31'd0, mem_wr}, 32'd1);
            check("st_addr", mem_a, a + 32'(k));
            check("st_data", {24'd0, mem_dout}, (v >> (8 * k)) & 32'hFF);
            check("st_busy", {31'd0, mem_busy}, 32'd1);
            model_mem[a + 32'(k)] = 8'((v >> (8 * k)) & 32'hFF);
            tick();
        end
        check("st_end_wr",   {31'd0, mem_wr}, 32'd0);
        check("st_end_busy", {31'd0, mem_busy}, 32'd0);
    endtask

    // Returns in the cycle mem_valid is seen (or after the cycle budget expires).
    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [5:0] dep,
                           output logic [31:0] got);
        int n;
        int cyc;
        logic [31:0] exp;
        n   = size_of(t[1:0]);
        exp = model_load(t, a);
        lsb_load_valid = 1'b1;
        lsb_load_type  = t;
        lsb_load_addr  = a;
        lsb_load_dep   = dep;
        tick();
        cyc = 1;
        check("ld_ack", {31'd0, lsb_load_ack}, 32'd1);
        lsb_load_valid = 1'b0;
        while (!mem_valid && cyc < 20) begin
            if (cyc <= n) begin
                check("ld_addr", mem_a, a + 32'(cyc - 1));
                check("ld_wr",   {31'd0, mem_wr}, 32'd0);
            end
            if (cyc == 2) check("ld_ack_pulse", {31'd0, lsb_load_ack}, 32'd0);
            tick();
            cyc++;
        end
        check("ld_valid",   {31'd0, mem_valid}, 32'd1);
        check("ld_latency", 32'(cyc), 32'(n + 2));
        check("ld_value",   mem_value, exp);
        check("ld_dep",     {26'd0, mem_dependency}, {26'd0, dep});
        got = mem_value;
    endtask

    initial begin
        logic [31:0] got;
        int          c;
        logic [2:0]  ld_types [5];
        ld_types = '{T_LB, T_LH, T_LW, T_LBU, T_LHU};

        // Reset state
        tick();
        tick();
        check_reset_vals("rst_init");
        rst_in = 1'b0;
        tick();
        check("idle_busy", {31'd0, mem_busy}, 32'd0);

        // Word store, little-endian byte order
        do_store(2'b10, 32'h100, 32'hDEADBEEF);

        // Sign and zero extension
        do_store(2'b00, 32'h200, 32'h00000080);
        do_load(T_LB, 32'h200, 6'd5, got);
        check("lb_const", got, 32'hFFFFFF80);
        do_load(T_LBU, 32'h200, 6'd6, got);
        check("lbu_const", got, 32'h00000080);
        do_store(2'b01, 32'h210, 32'h00009234);
        do_load(T_LH, 32'h210, 6'd7, got);
        check("lh_const", got, 32'hFFFF9234);
        do_load(T_LHU, 32'h210, 6'd8, got);
        check("lhu_const", got, 32'h00009234);

        // Store wins a simultaneous store/load in IDLE
        do_store(2'b10, 32'h400, 32'hCAFEF00D);
        rob_store_valid = 1'b1; rob_store_type = 2'b01;
        rob_store_addr  = 32'h300; rob_store_value = 32'h0000ABCD;
        lsb_load_valid  = 1'b1; lsb_load_type = T_LW;
        lsb_load_addr   = 32'h400; lsb_load_dep = 6'd9;
        #1 check("col_busy", {31'd0, mem_busy}, 32'd1);
        tick();
        rob_store_valid = 1'b0;
        check("col_wr0",   {31'd0, mem_wr}, 32'd1);
        check("col_a0",    mem_a, 32'h300);
        check("col_d0",    {24'd0, mem_dout}, 32'hCD);
        check("col_ack0",  {31'd0, lsb_load_ack}, 32'd0);
        tick();
        check("col_a1",    mem_a, 32'h301);
        check("col_d1",    {24'd0, mem_dout}, 32'hAB);
        check("col_ack1",  {31'd0, lsb_load_ack}, 32'd0);
        tick();
        check("col_wr_end", {31'd0, mem_wr}, 32'd0);
        check("col_ack2",   {31'd0, lsb_load_ack}, 32'd0);
        model_mem[32'h300] = 8'hCD;
        model_mem[32'h301] = 8'hAB;
        tick();
        check("col_ack", {31'd0, lsb_load_ack}, 32'd1);
        lsb_load_valid = 1'b0;
        c = 0;
        while (!mem_valid && c < 20) begin
            tick();
            c++;
        end
        check("col_lw_latency", 32'(c), 32'd5);
        check("col_lw_value",   mem_value, 32'hCAFEF00D);
        check("col_lw_dep",     {26'd0, mem_dependency}, 32'd9);
        tick();
        do_load(T_LHU, 32'h300, 6'd10, got);
        check("col_half_mem", got, 32'h0000ABCD);

        // Flush at the second load address
        lsb_load_valid = 1'b1; lsb_load_type = T_LW;
        lsb_load_addr  = 32'h500; lsb_load_dep = 6'd11;
        tick();
        check("fl_ack", {31'd0, lsb_load_ack}, 32'd1);
        lsb_load_valid = 1'b0;
        check("fl_a0", mem_a, 32'h500);
        tick();
        check("fl_a1", mem_a, 32'h501);
        need_flush_in = 1'b1;
        tick();
        need_flush_in = 1'b0;
        check("fl_idle_busy", {31'd0, mem_busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("fl_no_valid", {31'd0, mem_valid}, 32'd0);
            check("fl_addr_hold", mem_a, 32'h501);
            tick();
        end

        // Store ignores flush and freezes through a rdy_in stall
        rob_store_valid = 1'b1; rob_store_type = 2'b10;
        rob_store_addr  = 32'h600; rob_store_value = 32'h11223344;
        tick();
        rob_store_valid = 1'b0;
        check("sst_a0", mem_a, 32'h600);
        check("sst_d0", {24'd0, mem_dout}, 32'h44);
        tick();
        check("sst_a1", mem_a, 32'h601);
        check("sst_d1", {24'd0, mem_dout}, 32'h33);
        need_flush_in = 1'b1;
        tick();
        need_flush_in = 1'b0;
        check("sst_a2", mem_a, 32'h602);
        check("sst_wr2", {31'd0, mem_wr}, 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sst_stall_wr",   {31'd0, mem_wr}, 32'd0);
            check("sst_stall_addr", mem_a, 32'h602);
            check("sst_stall_data", {24'd0, mem_dout}, 32'h22);
            tick();
        end
        rdy_in = 1'b1;
        #1;
        check("sst_resume_wr", {31'd0, mem_wr}, 32'd1);
        check("sst_resume_a",  mem_a, 32'h602);
        tick();
        check("sst_a3", mem_a, 32'h603);
        check("sst_d3", {24'd0, mem_dout}, 32'h11);
        tick();
        check("sst_end_busy", {31'd0, mem_busy}, 32'd0);
        for (int k = 0; k < 4; k++)
            model_mem[32'h600 + 32'(k)] = 8'((32'h11223344 >> (8 * k)) & 32'hFF);
        do_load(T_LW, 32'h600, 6'd12, got);
        check("sst_mem_word", got, 32'h11223344);
        tick();

        // Address wrap at 0xFFFFFFFF
        do_store(2'b10, 32'hFFFFFFFE, 32'h89ABCDEF);
        do_load(T_LW, 32'hFFFFFFFE, 6'd13, got);
        check("wrap_word", got, 32'h89ABCDEF);

        // Randomized mix; loads issued back to back in the mem_valid cycle
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h1000 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                do_store(2'($urandom_range(0, 2)), a, $urandom);
            else
                do_load(ld_types[$urandom_range(0, 4)], a, 6'($urandom), got);
        end
        tick();

        // Asynchronous reset in the middle of a load
        lsb_load_valid = 1'b1; lsb_load_type = T_LW;
        lsb_load_addr  = 32'h700; lsb_load_dep = 6'd14;
        tick();
        lsb_load_valid = 1'b0;
        tick();
        check("ar_mid_addr", mem_a, 32'h701);
        #2 rst_in = 1'b1;
        #1 check_reset_vals("rst_async");
        tick();
        rst_in = 1'b0;
        tick();
        check("ar_after_busy",  {31'd0, mem_busy}, 32'd0);
        check("ar_after_valid", {31'd0, mem_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
